// File: rtl/wb_regfile.sv
// wb_regfile: integer register file with same-cycle write-back bypass; optional WB_RETIRE_CNT_EN adds a committed-write counter
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       wb_cnt_o
`endif
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    assign commit = we && (waddr != '0);

    // storage: async clear, x0 never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[waddr] <= wdata;
        end
    end

    // read ports: reset, disable and x0 force zero; a matching write is bypassed
    always_comb begin
        rdata1 = (!rst || !re1 || raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
        rdata2 = (!rst || !re2 || raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
    end

`ifdef WB_RETIRE_CNT_EN
    // counts writes that actually land in the file; wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wb_cnt_o <= '0;
        else if (commit) wb_cnt_o <= wb_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven check of wb_regfile reads, writes, bypass and reset
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] wb_cnt_o;
    logic [31:0] c0;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [12];

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .re1(re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2(re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
`ifdef WB_RETIRE_CNT_EN
        ,
        .wb_cnt_o(wb_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd6,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  1'b1, 5'd7,  32'h11,       32'h11};
        vecs[5]  = '{1'b1, 5'd7,  32'h22,       1'b1, 5'd7,  1'b1, 5'd7,  32'h22,       32'h22};
        vecs[6]  = '{1'b0, 5'd7,  32'h33,       1'b1, 5'd7,  1'b1, 5'd7,  32'h22,       32'h22};
        vecs[7]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 1'b1, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 5'd1,  32'hFFFFFFFF, 1'b1, 5'd31, 1'b1, 5'd1,  32'hA5A5A5A5, 32'hFFFFFFFF};
        vecs[9]  = '{1'b0, 5'd1,  32'h0,        1'b1, 5'd1,  1'b0, 5'd31, 32'hFFFFFFFF, 32'h0};
        vecs[10] = '{1'b1, 5'd5,  32'h0,        1'b1, 5'd5,  1'b1, 5'd7,  32'h0,        32'h22};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd31, 32'h0,        32'hA5A5A5A5};

        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd31;
        repeat (2) @(negedge clk);
        #1;
        chk("init_rst_rd1", rdata1, 32'h0);
        chk("init_rst_rd2", rdata2, 32'h0);
`ifdef WB_RETIRE_CNT_EN
        chk("init_rst_cnt", wb_cnt_o, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            re1 = vecs[i].re1; raddr1 = vecs[i].raddr1;
            re2 = vecs[i].re2; raddr2 = vecs[i].raddr2;
            #2;
            chk($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
            chk($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
        end

        // reset between edges zeroes every address immediately
        @(negedge clk);
        we = 1'b0; re1 = 1'b1; re2 = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_all_rd1_x%0d", i), rdata1, 32'h0);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("rst_all_cnt", wb_cnt_o, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        raddr1 = 5'd31; raddr2 = 5'd1;
        #1;
        chk("post_rst_x31", rdata1, 32'h0);
        chk("post_rst_x1", rdata2, 32'h0);

        // rewrite x7 so the mid-write reset has something to clear
        we = 1'b1; waddr = 5'd7; wdata = 32'h22;
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
        raddr1 = 5'd3; raddr2 = 5'd7;
        #1;
        chk("midwr_bypass", rdata1, 32'hAA);
        chk("midwr_x7", rdata2, 32'h22);
        #1 rst = 1'b0;
        #1;
        chk("midwr_rst_rd1", rdata1, 32'h0);
        chk("midwr_rst_rd2", rdata2, 32'h0);
        @(negedge clk);
        rst = 1'b1; we = 1'b0;
        #1;
        chk("midwr_lost_x3", rdata1, 32'h0);
        chk("midwr_clr_x7", rdata2, 32'h0);

        // first edge after release already commits
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000CAFE;
        @(negedge clk);
        we = 1'b0; raddr1 = 5'd9;
        #1;
        chk("first_wr_x9", rdata1, 32'h0000CAFE);

`ifdef WB_RETIRE_CNT_EN
        c0 = wb_cnt_o;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            we = 1'b1;
            waddr = (k % 3 == 0 && k < 9) ? 5'd0 : 5'(k + 1);
            wdata = 32'(k);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("cnt_delta7", wb_cnt_o, c0 + 32'd7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
